// File: rtl/weight_loader_param.sv
// Layer weight loader: streams TOTAL_WEIGHTS words from BRAM starting at BASE_ADDR into a
// flattened weight bus, with a per-word capture stream and restart from DONE.
module weight_loader_param #(
    parameter int IN_SIZE       = 256,
    parameter int OUT_SIZE      = 8,
    parameter int W             = 8,
    parameter int TOTAL_WEIGHTS = IN_SIZE * OUT_SIZE,
    parameter int ADDR_WIDTH    = 15,
    parameter int BASE_ADDR     = 14336,
    parameter int READ_LATENCY  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          bram_en,
    output logic [ADDR_WIDTH-1:0]         bram_addr,
    input  logic [W-1:0]                  bram_dout,
    output logic [TOTAL_WEIGHTS*W-1:0]    data_out,
    output logic                          wt_valid,
    output logic [ADDR_WIDTH:0]           wt_idx,
    output logic [W-1:0]                  wt_data,
    output logic                          busy,
    output logic                          done,
    output logic                          done_pulse
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]         LAST_IDX = CW'(TOTAL_WEIGHTS - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

    generate
        if (TOTAL_WEIGHTS < 1 ||
            (longint'(BASE_ADDR) + longint'(TOTAL_WEIGHTS) - 64'sd1) >= (64'sd1 <<< ADDR_WIDTH)) begin : g_bad_range
            $error("weight_loader_param: BASE_ADDR+TOTAL_WEIGHTS-1 does not fit in ADDR_WIDTH");
        end
        if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
            $error("weight_loader_param: READ_LATENCY must be 1..4");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                       state_q, state_d;
    logic [CW-1:0]                issue_cnt_q, issue_cnt_d;
    logic [CW-1:0]                wr_ptr_q, wr_ptr_d;
    logic [READ_LATENCY-1:0]      vpipe_q, vpipe_d;
    logic [TOTAL_WEIGHTS*W-1:0]   data_out_q, data_out_d;
    logic                         wt_valid_q, wt_valid_d;
    logic [CW-1:0]                wt_idx_q, wt_idx_d;
    logic [W-1:0]                 wt_data_q, wt_data_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic                         done_pulse_q, done_pulse_d;
    logic                         capture_s;

    // BRAM strobe and address decode straight from state and issue count
    always_comb begin
        bram_en   = 1'b0;
        bram_addr = BASE;
        if (state_q == S_ISSUE) begin
            bram_en   = 1'b1;
            bram_addr = BASE + issue_cnt_q[ADDR_WIDTH-1:0];
        end else begin
            bram_en   = 1'b0;
            bram_addr = BASE;
        end
    end

    // Next-state, capture path and registered output computation
    always_comb begin
        state_d      = state_q;
        issue_cnt_d  = issue_cnt_q;
        wr_ptr_d     = wr_ptr_q;
        data_out_d   = data_out_q;
        wt_valid_d   = 1'b0;
        wt_idx_d     = wt_idx_q;
        wt_data_d    = wt_data_q;
        done_d       = done_q;
        done_pulse_d = 1'b0;

        // The valid pipe tracks each issued read so capture lines up with BRAM latency.
        vpipe_d    = vpipe_q << 1;
        vpipe_d[0] = (state_q == S_ISSUE);
        capture_s  = vpipe_q[READ_LATENCY-1];

        if (capture_s) begin
            data_out_d[wr_ptr_q*W +: W] = bram_dout;
            wt_valid_d = 1'b1;
            wt_idx_d   = wr_ptr_q;
            wt_data_d  = bram_dout;
            wr_ptr_d   = wr_ptr_q + CW'(1);
        end else begin
            wr_ptr_d   = wr_ptr_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_ISSUE;
                    issue_cnt_d = '0;
                    wr_ptr_d    = '0;
                end else begin
                    state_d     = S_IDLE;
                end
            end
            S_ISSUE: begin
                issue_cnt_d = issue_cnt_q + CW'(1);
                if (issue_cnt_q == LAST_IDX) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_DRAIN: begin
                if (capture_s && (wr_ptr_q == LAST_IDX)) begin
                    state_d      = S_DONE;
                    done_d       = 1'b1;
                    done_pulse_d = 1'b1;
                end else begin
                    state_d      = S_DRAIN;
                end
            end
            S_DONE: begin
                // Reload keeps the old weights; they are overwritten word by word.
                if (start) begin
                    state_d     = S_ISSUE;
                    issue_cnt_d = '0;
                    wr_ptr_d    = '0;
                    done_d      = 1'b0;
                end else begin
                    state_d     = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_ISSUE) || (state_d == S_DRAIN);
    end

    // State and output registers; reset aborts any load and drops in-flight reads
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            issue_cnt_q  <= '0;
            wr_ptr_q     <= '0;
            vpipe_q      <= '0;
            data_out_q   <= '0;
            wt_valid_q   <= 1'b0;
            wt_idx_q     <= '0;
            wt_data_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            done_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            issue_cnt_q  <= issue_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            vpipe_q      <= vpipe_d;
            data_out_q   <= data_out_d;
            wt_valid_q   <= wt_valid_d;
            wt_idx_q     <= wt_idx_d;
            wt_data_q    <= wt_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            done_pulse_q <= done_pulse_d;
        end
    end

    assign data_out   = data_out_q;
    assign wt_valid   = wt_valid_q;
    assign wt_idx     = wt_idx_q;
    assign wt_data    = wt_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign done_pulse = done_pulse_q;

endmodule

// File: tb/tb_weight_loader_param.sv
// Bench for weight_loader_param: timeline reference model for the default-size loader,
// plus two small instances exercising read latencies 1 and 4.
module tb_weight_loader_param;

    localparam int T    = 2048;
    localparam int L    = 2;
    localparam int BASE = 14336;

    logic              clk;
    logic              rst;
    logic              start;
    logic              s_start;
    logic              bram_en;
    logic [14:0]       bram_addr;
    logic [7:0]        bram_dout;
    logic [T*8-1:0]    data_out;
    logic              wt_valid;
    logic [15:0]       wt_idx;
    logic [7:0]        wt_data;
    logic              busy;
    logic              done;
    logic              done_pulse;

    logic [7:0]        mem [0:32767];
    logic [7:0]        bpipe [0:3];

    int n_cmp = 0;
    int n_bad = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    weight_loader_param #(
        .IN_SIZE(256), .OUT_SIZE(8), .W(8), .TOTAL_WEIGHTS(T),
        .ADDR_WIDTH(15), .BASE_ADDR(BASE), .READ_LATENCY(L)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .bram_en(bram_en), .bram_addr(bram_addr), .bram_dout(bram_dout),
        .data_out(data_out), .wt_valid(wt_valid), .wt_idx(wt_idx), .wt_data(wt_data),
        .busy(busy), .done(done), .done_pulse(done_pulse)
    );

    // BRAM with a configurable read pipeline
    always @(posedge clk) begin
        if (bram_en) bpipe[0] <= mem[bram_addr];
        for (int j = 1; j < 4; j++) bpipe[j] <= bpipe[j-1];
    end
    assign bram_dout = bpipe[L-1];

    // Reference model: everything follows from edges elapsed since an accepted start.
    bit             m_load = 1'b0;
    int             m_e    = 0;
    logic [T*8-1:0] exp_dout;
    logic [15:0]    exp_idx;
    logic [7:0]     exp_data;
    bit             e_valid;

    always @(posedge clk) begin
        if (rst) begin
            m_load   = 1'b0;
            m_e      = 0;
            exp_dout = '0;
            exp_idx  = '0;
            exp_data = '0;
        end else if (start && (!m_load || m_e >= T + L)) begin
            m_load = 1'b1;
            m_e    = 0;
        end else if (m_load && m_e <= T + L) begin
            m_e++;
        end
        e_valid = !rst && m_load && m_e >= L + 1 && m_e <= T + L;
        if (e_valid) begin
            exp_idx  = 16'(m_e - L - 1);
            exp_data = mem[BASE + int'(exp_idx)];
            exp_dout[int'(exp_idx)*8 +: 8] = exp_data;
        end
        #1;
        chk("bram_en", bram_en, m_load && m_e < T);
        chk("bram_addr", bram_addr, (m_load && m_e < T) ? 15'(BASE + m_e) : 15'(BASE));
        chk("busy", busy, m_load && m_e < T + L);
        chk("done", done, m_load && m_e >= T + L);
        chk("done_pulse", done_pulse, m_load && m_e == T + L);
        chk("wt_valid", wt_valid, e_valid);
        chk("wt_idx", wt_idx, exp_idx);
        chk("wt_data", wt_data, exp_data);
        chk("data_out_differs", 64'(data_out !== exp_dout), 64'd0);
    end

    // Small loaders (8 words) at read latency 1 and 4
    for (genvar g = 0; g < 2; g++) begin : g_small
        localparam int SL       = (g == 0) ? 1 : 4;
        localparam int EXP_EDGE = (g == 0) ? 9 : 12;
        logic        en_s;
        logic [14:0] addr_s;
        logic [7:0]  dout_s;
        logic [63:0] bus_s;
        logic        wv_s;
        logic [15:0] idx_s;
        logic [7:0]  wd_s;
        logic        busy_s;
        logic        done_s;
        logic        dp_s;
        logic [7:0]  pipe_s [0:3];
        int          ecnt = 0;
        int          nidx = 0;
        bit          run  = 1'b0;

        weight_loader_param #(
            .IN_SIZE(4), .OUT_SIZE(2), .W(8), .TOTAL_WEIGHTS(8),
            .ADDR_WIDTH(15), .BASE_ADDR(BASE), .READ_LATENCY(SL)
        ) u_small (
            .clk(clk), .rst(rst), .start(s_start),
            .bram_en(en_s), .bram_addr(addr_s), .bram_dout(dout_s),
            .data_out(bus_s), .wt_valid(wv_s), .wt_idx(idx_s), .wt_data(wd_s),
            .busy(busy_s), .done(done_s), .done_pulse(dp_s)
        );

        always @(posedge clk) begin
            if (en_s) pipe_s[0] <= mem[addr_s];
            for (int j = 1; j < 4; j++) pipe_s[j] <= pipe_s[j-1];
        end
        assign dout_s = pipe_s[SL-1];

        always @(posedge clk) begin
            if (!rst && s_start && !run) begin
                run  = 1'b1;
                ecnt = 0;
                nidx = 0;
            end else if (run) begin
                ecnt++;
            end
            #1;
            if (run) begin
                if (wv_s) begin
                    chk($sformatf("lat%0d_wt_idx", SL), idx_s, 64'(nidx));
                    chk($sformatf("lat%0d_wt_data", SL), wd_s, mem[BASE + nidx]);
                    nidx++;
                end
                chk($sformatf("lat%0d_done", SL), done_s, 64'(ecnt >= EXP_EDGE));
                if (ecnt >= EXP_EDGE) begin
                    chk($sformatf("lat%0d_pulse", SL), dp_s, 64'd1);
                    chk($sformatf("lat%0d_words", SL), 64'(nidx), 64'd8);
                    for (int i = 0; i < 8; i++)
                        chk($sformatf("lat%0d_word%0d", SL, i), bus_s[i*8 +: 8], mem[BASE + i]);
                    run = 1'b0;
                end
            end
        end
    end

    // One load from a start pulse; returns edges to done, bram_en cycles and pulse count
    task automatic run_load(input bit spam, output int n, output int en_cnt, output int pulses);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done_falls_after_start", done, 64'd0);
        n = 0;
        en_cnt = int'(bram_en);
        pulses = int'(done_pulse);
        while (!done && n < 6000) begin
            if (spam && n >= 2 && n <= 9) start = (n == 5) ? 1'b1 : 1'($urandom_range(0, 1));
            else start = 1'b0;
            @(negedge clk);
            n++;
            en_cnt += int'(bram_en);
            pulses += int'(done_pulse);
        end
        chk("done_within_bound", done, 64'd1);
        repeat (3) begin
            @(negedge clk);
            en_cnt += int'(bram_en);
            pulses += int'(done_pulse);
        end
    endtask

    task automatic check_data(input string tag);
        for (int i = 0; i < T; i++) begin
            chk(tag, data_out[i*8 +: 8], mem[BASE + i]);
        end
    endtask

    task automatic randomize_mem();
        for (int a = BASE; a < BASE + T; a++) mem[a] = 8'($urandom);
    endtask

    initial begin
        int n;
        int en_cnt;
        int pulses;
        int p;
        rst = 1'b1;
        start = 1'b0;
        s_start = 1'b0;
        for (int a = 0; a < 32768; a++) mem[a] = a[7:0];
        repeat (3) @(negedge clk);
        chk("rst_bram_addr", bram_addr, 64'd14336);
        chk("rst_data_out_zero", 64'(|data_out), 64'd0);
        chk("rst_busy", busy, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // T1 + T2: default loader and both small loaders from one start
        s_start = 1'b1;
        fork
            run_load(1'b0, n, en_cnt, pulses);
            begin
                @(negedge clk);
                s_start = 1'b0;
            end
        join
        chk("t1_done_edge", 64'(n), 64'd2050);
        chk("t1_en_cycles", 64'(en_cnt), 64'd2048);
        chk("t1_pulses", 64'(pulses), 64'd1);
        chk("t1_word0", data_out[7:0], 64'h00);
        chk("t1_word2047", data_out[T*8-1 -: 8], 64'hFF);
        chk("t1_word5", data_out[47:40], 64'h05);
        check_data("t1_data");

        // T3: start pulses while busy are ignored
        run_load(1'b1, n, en_cnt, pulses);
        chk("t3_done_edge", 64'(n), 64'd2050);
        chk("t3_en_cycles", 64'(en_cnt), 64'd2048);
        chk("t3_pulses", 64'(pulses), 64'd1);

        // T4: reset mid-load, then a clean reload of new contents
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (99) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t4_busy", busy, 64'd0);
        chk("t4_bram_en", bram_en, 64'd0);
        chk("t4_bram_addr", bram_addr, 64'd14336);
        chk("t4_data_out_zero", 64'(|data_out), 64'd0);
        chk("t4_wt_valid", wt_valid, 64'd0);
        chk("t4_wt_idx", wt_idx, 64'd0);
        chk("t4_wt_data", wt_data, 64'd0);
        chk("t4_done", done, 64'd0);
        chk("t4_done_pulse", done_pulse, 64'd0);
        rst = 1'b0;
        randomize_mem();
        run_load(1'b0, n, en_cnt, pulses);
        chk("t4_done_edge", 64'(n), 64'd2050);
        chk("t4_pulses", 64'(pulses), 64'd1);
        check_data("t4_data");

        // T5: reload from DONE with changed contents
        randomize_mem();
        run_load(1'b0, n, en_cnt, pulses);
        chk("t5_done_edge", 64'(n), 64'd2050);
        chk("t5_en_cycles", 64'(en_cnt), 64'd2048);
        check_data("t5_data");

        // T6: start held high loads back to back
        randomize_mem();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        n = 0;
        p = 0;
        while (n < 10000) begin
            if (done_pulse) p++;
            if (p == 2) break;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("t6_pulses", 64'(p), 64'd2);
        chk("t6_second_done_edge", 64'(n), 64'd4101);
        repeat (5) @(negedge clk);
        chk("t6_done_held", done, 64'd1);
        check_data("t6_data");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
